bus_arbiter_rr: RTL and testbench
=================================

Name: bus_arbiter_rr

Overview:
- Round-robin arbiter that shares the 32-bit internal CPU bus among up to 32 bus sources (registers, PC, MDR, ALU result, ...).
- Replaces ad-hoc priority selection. Each requester holds its request for as long as it wants the bus; it is released by dropping the request.
- Produces a registered one-hot grant plus the 5-bit encoded source index that drives the bus multiplexer select.

Parameters:
- NUM_REQ, 32, number of requesters (2..32).
- IDX_W, 5, width of the encoded index; must satisfy 2**IDX_W >= NUM_REQ.
- MAX_HOLD, 16, maximum consecutive grant cycles before forced rotation (only with ARB_TIMEOUT_EN); range 2..255.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  synchronous active-high reset, sampled on the rising edge of clk.
- req  in  NUM_REQ  per-source bus request; level, held for the duration of the transfer.
- gnt  out  NUM_REQ  one-hot grant, registered; all-zero when the bus is idle.
- gnt_idx  out  IDX_W  binary index of the granted source, registered; 0 when idle.
- gnt_valid  out  1  high when any grant is active.
- rotate_ptr  out  IDX_W  current round-robin search start index; debug/verification visibility.

Behaviour:
- Reset (clr=1 at an edge), regardless of state:
  - gnt=0, gnt_idx=0, gnt_valid=0.
  - rotate_ptr=0, hold counter=0, FSM=IDLE.
  - Reset mid-grant drops the grant at that edge with no completion.
- States: IDLE, GRANT.
- IDLE:
  - If req!=0, select the first set bit searching upward from rotate_ptr, wrapping NUM_REQ-1 -> 0.
  - Next edge: gnt=onehot(sel), gnt_idx=sel, gnt_valid=1, hold counter=1, FSM=GRANT.
  - Latency from request to grant is one cycle.
  - If req=0, remain in IDLE with outputs at zero.
- GRANT, owner=o:
  - If req[o]=1 (and no timeout), keep the grant unchanged and increment the hold counter. The counter saturates at 255.
  - If req[o]=0 and other requests are pending, re-arbitrate in the same cycle. The new grant is applied at the next edge with no idle bubble.
  - If req[o]=0 and no other requests are pending: next edge gnt=0, gnt_valid=0, gnt_idx=0, FSM=IDLE.
- Pointer update: whenever a grant is issued to index s, rotate_ptr <= (s+1) mod NUM_REQ at the same edge. The owner therefore has the lowest priority in the next arbitration.
- Arbitration search excludes the current owner when rotating away from it.
- Requests with index >= NUM_REQ do not exist; NUM_REQ<32 uses only the low bits.
- Simultaneous events:
  - If the owner drops req in the same cycle another source raises req, the newly raised source is eligible in that arbitration.
  - clr has priority over everything.
- Invariants: gnt is always zero or one-hot; gnt_idx always equals the index of the set bit in gnt; gnt_valid == |gnt.
- A requester dropping req while not granted is legal; no state is kept per requester.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - When the hold counter reaches MAX_HOLD while req[o] is still 1 and another request is pending, the arbiter forcibly rotates.
  - The next edge grants the next requester in round-robin order; rotate_ptr updates as normal.
  - If no other request is pending, the owner keeps the grant and the counter holds at MAX_HOLD.
  - A new grant reloads the counter to 1.
- Undefined: no timeout; the owner keeps the bus until it drops req. The hold counter logic is removed.

Test Plan:
- Reset: drive clr=1 for 2 cycles with req=32'hFFFF_FFFF -> gnt=0, gnt_idx=0, gnt_valid=0, rotate_ptr=0 throughout. Release clr -> gnt=32'h0000_0001, gnt_idx=0 one cycle later.
- Single requester: req=32'h0000_0100 for 3 cycles, then 0 -> gnt=32'h0000_0100 and gnt_idx=8 for exactly 3 cycles starting one cycle after req. Then gnt=0; rotate_ptr=9.
- Round-robin fairness: req=32'h8000_0003 with each owner holding 1 cycle then dropping/reasserting -> grant order idx 0,1,31,0,1,31 with no idle cycle between grants.
- Wrap-around: rotate_ptr=31 (after granting idx 30), req=32'h8000_0004 -> next grant idx 31, then idx 2. rotate_ptr goes 31 -> 0 -> 3.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=16): req[5] and req[6] held high continuously -> idx 5 granted 16 cycles, then idx 6 for 16 cycles, alternating. Without the macro, idx 5 holds indefinitely.
- Reset mid-grant: idx 12 granted, assert clr for 1 cycle with req[12] still high -> gnt=0 at that edge. Grant to idx 12 reissued one cycle after clr drops; rotate_ptr=0 before the regrant.

Source files
------------

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin arbiter sharing the internal CPU bus among NUM_REQ sources.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   clr        synchronous active-high reset, has priority over everything
//   req        per-source level request, held for the duration of the transfer
//   gnt        registered one-hot grant, all-zero when the bus is idle
//   gnt_idx    registered binary index of the granted source, 0 when idle
//   gnt_valid  high while any grant is active (== |gnt)
//   rotate_ptr round-robin search start index (debug visibility)
//
// Optional feature: define ARB_TIMEOUT_EN to force rotation after MAX_HOLD
// consecutive grant cycles when another source is waiting.
module bus_arbiter_rr #(
    parameter int NUM_REQ  = 32,
    parameter int IDX_W    = 5,
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic [IDX_W-1:0]   rotate_ptr
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state, state_nxt;
    logic [NUM_REQ-1:0] elig;
    logic [IDX_W-1:0]   sel;
    logic               found;
    logic               owner_req;
    logic               expire;
    logic               keep;
    logic               issue;
`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
    logic [7:0] hold_cnt;
    assign expire = hold_cnt >= HOLD_MAX;
`else
    assign expire = 1'b0;
`endif
    assign owner_req = |(req & gnt);
    // The owner is masked out so a re-arbitration always rotates away from it.
    assign elig = (state == GRANT) ? (req & ~gnt) : req;
    // Walk downward so the candidate closest to rotate_ptr is written last and wins.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            int k;
            k = int'(rotate_ptr) + i;
            k = (k >= NUM_REQ) ? k - NUM_REQ : k;
            if (elig[k[IDX_W-1:0]]) begin
                sel   = k[IDX_W-1:0];
                found = 1'b1;
            end
        end
    end
    // Owner keeps the bus while requesting, unless timed out with someone waiting.
    always_comb begin
        keep      = (state == GRANT) && owner_req && (!expire || !found);
        issue     = found && !keep;
        state_nxt = (keep || issue) ? GRANT : IDLE;
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= IDLE;
            gnt        <= '0;
            gnt_idx    <= '0;
            gnt_valid  <= 1'b0;
            rotate_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (issue) begin
                gnt        <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;
                gnt_idx    <= sel;
                gnt_valid  <= 1'b1;
                rotate_ptr <= (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
            end else if (!keep) begin
                gnt       <= '0;
                gnt_idx   <= '0;
                gnt_valid <= 1'b0;
            end
        end
    end
`ifdef ARB_TIMEOUT_EN
    // Counts consecutive owner cycles; stops at MAX_HOLD when nobody else waits.
    always_ff @(posedge clk) begin
        if (clr)
            hold_cnt <= '0;
        else if (issue)
            hold_cnt <= 8'd1;
        else if (keep)
            hold_cnt <= (expire || hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
        else
            hold_cnt <= '0;
    end
`endif
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: directed scoreboard bench for bus_arbiter_rr.
module tb_bus_arbiter_rr;
    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] req = '1;
    logic [31:0] gnt;
    logic [4:0]  gnt_idx;
    logic        gnt_valid;
    logic [4:0]  rotate_ptr;
    int passed = 0;
    int total  = 0;

    typedef struct {
        logic       v;
        logic [4:0] idx;
        logic [4:0] ptr;
        string      tag;
    } exp_t;
    exp_t sb[$];

    bus_arbiter_rr #(.NUM_REQ(32), .IDX_W(5), .MAX_HOLD(16)) dut (
        .clk(clk), .clr(clr), .req(req), .gnt(gnt),
        .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .rotate_ptr(rotate_ptr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) passed++;
        else $error("FAIL %s got %h want %h", tag, got, want);
    endtask

    task automatic step(input logic c, input logic [31:0] r, input logic v,
                        input logic [4:0] idx, input logic [4:0] ptr, input string tag);
        exp_t e;
        @(negedge clk);
        clr = c;
        req = r;
        sb.push_back('{v, idx, ptr, tag});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_gnt"}, gnt, e.v ? (32'd1 << e.idx) : 32'd0);
            chk({e.tag, "_idx"}, {27'd0, gnt_idx}, {27'd0, e.v ? e.idx : 5'd0});
            chk({e.tag, "_valid"}, {31'd0, gnt_valid}, {31'd0, e.v});
            chk({e.tag, "_ptr"}, {27'd0, rotate_ptr}, {27'd0, e.ptr});
        end
    endtask

    initial begin
        step(1, '1, 0, 0, 0, "rst0");
        step(1, '1, 0, 0, 0, "rst1");
        step(0, '1, 1, 0, 1, "rst_rel");
        step(1, '0, 0, 0, 0, "rst2");
        step(0, 32'h0000_0100, 1, 8, 9, "single1");
        step(0, 32'h0000_0100, 1, 8, 9, "single2");
        step(0, 32'h0000_0100, 1, 8, 9, "single3");
        step(0, 32'h0, 0, 0, 9, "single_drop");
        step(0, 32'h0, 0, 0, 9, "idle");
        step(1, 32'h0, 0, 0, 0, "rst3");
        step(0, 32'h8000_0003, 1, 0, 1, "rr0");
        step(0, 32'h8000_0002, 1, 1, 2, "rr1");
        step(0, 32'h8000_0001, 1, 31, 0, "rr31");
        step(0, 32'h0000_0003, 1, 0, 1, "rr0b");
        step(0, 32'h8000_0002, 1, 1, 2, "rr1b");
        step(0, 32'h8000_0001, 1, 31, 0, "rr31b");
        step(0, 32'h0, 0, 0, 0, "rr_idle");
        step(0, 32'h4000_0000, 1, 30, 31, "wrap30");
        step(0, 32'h8000_0004, 1, 31, 0, "wrap31");
        step(0, 32'h0000_0004, 1, 2, 3, "wrap2");
        step(0, 32'h0, 0, 0, 3, "wrap_idle");
        for (int n = 0; n < 40; n++) begin
`ifdef ARB_TIMEOUT_EN
            if (((n / 16) % 2) == 1)
                step(0, 32'h0000_0060, 1, 6, 7, "tmo6");
            else
                step(0, 32'h0000_0060, 1, 5, 6, "tmo5");
`else
            step(0, 32'h0000_0060, 1, 5, 6, "hold5");
`endif
        end
        step(0, 32'h0, 0, 0, 6, "hold_idle");
        step(0, 32'h0000_1000, 1, 12, 13, "mid12");
        step(0, 32'h0000_1000, 1, 12, 13, "mid12b");
        step(1, 32'h0000_1000, 0, 0, 0, "mid_clr");
        step(0, 32'h0000_1000, 1, 12, 13, "mid_regrant");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
